// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operand width,
// op encodings, FSM state type and the iteration count.
package mul_div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_t;

  // Two's-complement negate when n is set; used for magnitudes and sign fix-up.
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. acc_hi is the partial product / partial remainder, acc_lo the
// multiplier / quotient register.
module mul_div_step
  import mul_div_pkg::*;
(
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           borrow;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    borrow  = shifted < {1'b0, operand};
    acc_hi_next = '0;
    acc_lo_next = '0;
    if (div_mode) begin
      // The remainder stays below the divisor, so a 32-bit difference is exact.
      acc_hi_next = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - operand);
      acc_lo_next = {acc_lo[WIDTH-2:0], ~borrow};
    end else begin
      acc_hi_next = sum[WIDTH:1];
      acc_lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Handshake: start is taken only in IDLE (busy=0); done pulses one cycle when results land.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiLoWrite,
  input  logic             selHi,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);
  import mul_div_pkg::state_t;
  import mul_div_pkg::S_IDLE;
  import mul_div_pkg::S_PREP;
  import mul_div_pkg::S_RUN;
  import mul_div_pkg::S_FIX;
  import mul_div_pkg::ITER_COUNT;
  import mul_div_pkg::neg_if;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, zwait_q, zwait_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   step_hi, step_lo, a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic               signed_op, div_op;

  mul_div_step u_step (
    .div_mode    (div_op),
    .acc_hi      (acc_hi_q),
    .acc_lo      (acc_lo_q),
    .operand     (b_q),
    .acc_hi_next (step_hi),
    .acc_lo_next (step_lo)
  );

  always_comb begin
    signed_op = ~op_q[0];
    div_op    = op_q[1];
    a_mag     = neg_if(signed_op & a_q[WIDTH-1], a_q);
    b_mag     = neg_if(signed_op & b_q[WIDTH-1], b_q);
    prod_fix  = neg_q ? (~{acc_hi_q, acc_lo_q} + (2*WIDTH)'(1)) : {acc_hi_q, acc_lo_q};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    zwait_d  = zwait_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = srcA;
          b_d     = srcB;
          zwait_d = 1'b0;
          state_d = S_PREP;
        end else if (hiLoWrite) begin
          if (selHi) hi_d = writeData;
          else       lo_d = writeData;
        end
      end
      S_PREP: begin
        if (div_op && (b_q == '0)) begin
          // Divide by zero spends two cycles in PREP, then completes with HI/LO untouched.
          if (zwait_q) begin
            zwait_d = 1'b0;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            zwait_d = 1'b1;
          end
        end else begin
          neg_d    = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d   = signed_op & a_q[WIDTH-1];
          acc_hi_d = '0;
          acc_lo_d = div_op ? a_mag : b_mag;
          b_d      = div_op ? b_mag : a_mag;
          cnt_d    = 5'(ITER_COUNT - 1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (div_op) begin
          lo_d = neg_if(neg_q, acc_lo_q);
          hi_d = neg_if(rneg_q, acc_hi_q);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      zwait_q  <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      zwait_q  <= zwait_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule
